hs_wire_state_encoder: RTL and testbench

//  Downstream neighbour of the HS serializer in the C-PHY master TX path. Each TxSymbolClkHS

---
 rtl/cphy_tx_pkg.sv | 44 ++++
 rtl/hs_wire_state_next.sv | 44 ++++
 rtl/hs_wire_state_encoder.sv | 169 ++++++++++++++++
 tb/tb_hs_wire_state_encoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cphy_tx_pkg.sv
// Shared definitions for the C-PHY HS transmit path.
//   - Wire-state codes (WS_PX..WS_NZ): axis in code[2:1] (x/y/z), sign in code[0] (0 = +).
//   - Per-wire {PU,PD} drive levels (high, low, mid, off).
//   - Bit positions of Flip/Rotation/Polarity inside a serialized symbol.
//   - Encoder FSM state type.
//   - wire_levels(): maps a wire-state code to the {A,B,C} drive levels.
package cphy_tx_pkg;

  localparam logic [2:0] WS_PX = 3'd0;
  localparam logic [2:0] WS_NX = 3'd1;
  localparam logic [2:0] WS_PY = 3'd2;
  localparam logic [2:0] WS_NY = 3'd3;
  localparam logic [2:0] WS_PZ = 3'd4;
  localparam logic [2:0] WS_NZ = 3'd5;

  localparam logic [1:0] LVL_H   = 2'b10;
  localparam logic [1:0] LVL_L   = 2'b01;
  localparam logic [1:0] LVL_M   = 2'b11;
  localparam logic [1:0] LVL_OFF = 2'b00;

  localparam int SYM_FLIP = 2;
  localparam int SYM_ROT  = 1;
  localparam int SYM_POL  = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    POST   = 2'd2
  } enc_fsm_e;

  // Returns {WireA, WireB, WireC}; illegal codes turn all drivers off.
  function automatic logic [5:0] wire_levels(input logic [2:0] ws);
    case (ws)
      WS_PX:   wire_levels = {LVL_H, LVL_L, LVL_M};
      WS_NX:   wire_levels = {LVL_L, LVL_H, LVL_M};
      WS_PY:   wire_levels = {LVL_M, LVL_H, LVL_L};
      WS_NY:   wire_levels = {LVL_M, LVL_L, LVL_H};
      WS_PZ:   wire_levels = {LVL_L, LVL_M, LVL_H};
      WS_NZ:   wire_levels = {LVL_H, LVL_M, LVL_L};
      default: wire_levels = {LVL_OFF, LVL_OFF, LVL_OFF};
    endcase
  endfunction

endpackage

// File: rtl/hs_wire_state_next.sv
// Combinational wire-state transition function.
//   state_i : current wire-state code (must be 0..5; other codes are handled by the caller)
//   sym_i   : {Flip, Rotation, Polarity}
//   state_o : next wire-state code
// Flip toggles the sign on the same axis; otherwise the axis rotates forward (Rotation=1)
// or backward (Rotation=0) and the sign is kept only when Polarity=1.
module hs_wire_state_next
  import cphy_tx_pkg::*;
(
  input  logic [2:0] state_i,
  input  logic [2:0] sym_i,
  output logic [2:0] state_o
);

  logic [1:0] axis;
  logic       sign;
  logic [1:0] axis_n;
  logic       sign_n;

  always_comb begin
    axis   = state_i[2:1];
    sign   = state_i[0];
    axis_n = axis;
    sign_n = ~sign;
    if (!sym_i[SYM_FLIP]) begin
      if (sym_i[SYM_ROT]) begin
        case (axis)
          2'd0:    axis_n = 2'd1;
          2'd1:    axis_n = 2'd2;
          default: axis_n = 2'd0;
        endcase
      end else begin
        case (axis)
          2'd0:    axis_n = 2'd2;
          2'd1:    axis_n = 2'd0;
          default: axis_n = 2'd1;
        endcase
      end
      sign_n = sym_i[SYM_POL] ? sign : ~sign;
    end
    state_o = {axis_n, sign_n};
  end

endmodule

// File: rtl/hs_wire_state_encoder.sv
// C-PHY HS wire-state encoder: consumes one serialized symbol per TxSymbolClkHS cycle,
// advances the 6-state wire-state machine and drives the trio line controls.
// Optional macro: HS_ENC_OUT_REG_EN adds an output register on Wire*, HsDrvEn and
// WordBoundary (latency 2 instead of 1).
// Ports:
//   TxSymbolClkHS   in  symbol clock
//   RstN            in  synchronous active-low reset
//   HsEncEn         in  symbol valid
//   SerSym[2:0]     in  {Flip, Rotation, Polarity}
//   WireA/B/C[1:0]  out {PU,PD} per trio wire
//   HsDrvEn         out HS drivers enabled
//   WireState[2:0]  out current wire-state code
//   WordBoundary    out pulse on the last symbol of each word
//   EncBusy         out FSM not idle
//   IllegalStateErr out sticky illegal wire-state flag
module hs_wire_state_encoder
  import cphy_tx_pkg::*;
#(
  parameter logic [2:0] INIT_STATE    = 3'd0,
  parameter int         POST_CYCLES   = 7,
  parameter int         SYMS_PER_WORD = 7
) (
  input  logic       TxSymbolClkHS,
  input  logic       RstN,
  input  logic       HsEncEn,
  input  logic [2:0] SerSym,
  output logic [1:0] WireA,
  output logic [1:0] WireB,
  output logic [1:0] WireC,
  output logic       HsDrvEn,
  output logic [2:0] WireState,
  output logic       WordBoundary,
  output logic       EncBusy,
  output logic       IllegalStateErr
);

  localparam int PH_W   = (SYMS_PER_WORD > 1) ? $clog2(SYMS_PER_WORD) : 1;
  localparam int POST_W = (POST_CYCLES > 1) ? $clog2(POST_CYCLES) : 1;
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(SYMS_PER_WORD - 1);
  localparam logic [POST_W-1:0] POST_LAST = POST_W'(POST_CYCLES - 1);

  enc_fsm_e          fsm_q, fsm_d;
  logic [2:0]        ws_q, ws_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [POST_W-1:0] post_q, post_d;
  logic              wb_q, wb_d;
  logic              err_q, err_d;
  logic [2:0]        ws_next;
  logic              illegal;
  logic              apply;

  hs_wire_state_next u_next (
    .state_i (ws_q),
    .sym_i   (SerSym),
    .state_o (ws_next)
  );

  always_comb begin
    illegal = (ws_q > WS_NZ);
    fsm_d   = fsm_q;
    ws_d    = ws_q;
    phase_d = phase_q;
    post_d  = post_q;
    wb_d    = 1'b0;
    err_d   = err_q | illegal;
    apply   = 1'b0;

    case (fsm_q)
      IDLE: begin
        // First valid cycle only starts the burst; its symbol is the serializer's
        // pipeline fill and is dropped.
        if (HsEncEn) begin
          fsm_d   = ACTIVE;
          ws_d    = INIT_STATE;
          phase_d = '0;
        end
      end
      ACTIVE: begin
        if (HsEncEn) begin
          apply = 1'b1;
        end else begin
          fsm_d  = POST;
          post_d = '0;
        end
      end
      POST: begin
        // A resumed stream continues from the held state and word phase.
        if (HsEncEn) begin
          fsm_d = ACTIVE;
          apply = 1'b1;
        end else if (post_q == POST_LAST) begin
          fsm_d = IDLE;
        end else begin
          post_d = post_q + 1'b1;
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (apply) begin
      ws_d    = ws_next;
      wb_d    = (phase_q == PH_LAST);
      phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    // Corrupted state register recovers to the burst start state.
    if (illegal) begin
      ws_d = INIT_STATE;
    end
  end

  always_ff @(posedge TxSymbolClkHS) begin
    if (!RstN) begin
      fsm_q   <= IDLE;
      ws_q    <= INIT_STATE;
      phase_q <= '0;
      post_q  <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      ws_q    <= ws_d;
      phase_q <= phase_d;
      post_q  <= post_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  logic [5:0] wires_p0;
  logic       drv_p0;

  always_comb begin
    drv_p0   = (fsm_q != IDLE);
    wires_p0 = drv_p0 ? wire_levels(ws_q) : 6'b000000;
  end

  assign WireState       = ws_q;
  assign EncBusy         = (fsm_q != IDLE);
  assign IllegalStateErr = err_q;

`ifdef HS_ENC_OUT_REG_EN
  // Output register stage
  logic [5:0] wires_p1;
  logic       drv_p1;
  logic       wb_p1;

  always_ff @(posedge TxSymbolClkHS) begin
    if (!RstN) begin
      wires_p1 <= 6'b000000;
      drv_p1   <= 1'b0;
      wb_p1    <= 1'b0;
    end else begin
      wires_p1 <= wires_p0;
      drv_p1   <= drv_p0;
      wb_p1    <= wb_q;
    end
  end

  assign {WireA, WireB, WireC} = wires_p1;
  assign HsDrvEn               = drv_p1;
  assign WordBoundary          = wb_p1;
`else
  assign {WireA, WireB, WireC} = wires_p0;
  assign HsDrvEn               = drv_p0;
  assign WordBoundary          = wb_q;
`endif

endmodule

// File: tb/tb_hs_wire_state_encoder.sv
// Self-checking bench for hs_wire_state_encoder: directed vector table, hand-written
// multi-cycle sequences and a long randomized run against a behavioural model.
module tb_hs_wire_state_encoder;

`ifdef HS_ENC_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int INIT = 0;
  localparam int PC   = 7;
  localparam int SPW  = 7;

  logic       clk = 1'b0;
  logic       RstN = 1'b0;
  logic       HsEncEn = 1'b0;
  logic [2:0] SerSym = 3'd0;
  logic [1:0] WireA, WireB, WireC;
  logic       HsDrvEn, WordBoundary, EncBusy, IllegalStateErr;
  logic [2:0] WireState;

  always #5 clk = ~clk;

  hs_wire_state_encoder dut (
    .TxSymbolClkHS   (clk),
    .RstN            (RstN),
    .HsEncEn         (HsEncEn),
    .SerSym          (SerSym),
    .WireA           (WireA),
    .WireB           (WireB),
    .WireC           (WireC),
    .HsDrvEn         (HsDrvEn),
    .WireState       (WireState),
    .WordBoundary    (WordBoundary),
    .EncBusy         (EncBusy),
    .IllegalStateErr (IllegalStateErr)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model state: mode 0 = idle, 1 = streaming, 2 = post-hold.
  int   m_mode, m_ws, m_phase, m_post;
  logic m_wb, m_err, m_applied;
  logic [5:0] e_wires;
  logic       e_drv, e_wb;
  int         prev_ws;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string name, input int act, input int other);
    checks++;
    if (act == other) begin
      errors++;
      $display("FAIL %s: got %0d expected a value different from %0d (t=%0t)", name, act, other, $time);
    end
  endtask

  // Symbol rule on (axis, sign) pairs.
  function automatic int mnext(input int ws, input logic [2:0] s);
    int ax = ws / 2;
    int sg = ws % 2;
    if (s[2]) sg = 1 - sg;
    else begin
      ax = s[1] ? (ax + 1) % 3 : (ax + 2) % 3;
      if (!s[0]) sg = 1 - sg;
    end
    return ax * 2 + sg;
  endfunction

  // Positive-sign wire of axis k is wire k; its partner is wire k+1; the third is mid.
  function automatic logic [5:0] mwires(input int mode, input int ws);
    logic [1:0] lv [3];
    int ax, sg;
    if (mode == 0 || ws > 5) return 6'b000000;
    ax = ws / 2;
    sg = ws % 2;
    lv[(ax + sg) % 3]     = 2'b10;
    lv[(ax + 1 - sg) % 3] = 2'b01;
    lv[(ax + 2) % 3]      = 2'b11;
    return {lv[0], lv[1], lv[2]};
  endfunction

  task automatic model_edge(input logic rn, input logic en, input logic [2:0] sym);
    logic bad;
    logic [5:0] pre_wires = mwires(m_mode, m_ws);
    logic       pre_drv   = (m_mode != 0);
    logic       pre_wb    = m_wb;
    m_applied = 1'b0;
    if (!rn) begin
      m_mode = 0; m_ws = INIT; m_phase = 0; m_post = 0; m_wb = 1'b0; m_err = 1'b0;
      pre_wires = 6'b0; pre_drv = 1'b0; pre_wb = 1'b0;
    end else begin
      bad  = (m_ws > 5);
      m_wb = 1'b0;
      if (m_mode == 0) begin
        if (en) begin m_mode = 1; m_ws = INIT; m_phase = 0; end
      end else if (en) begin
        m_mode = 1;
        if (!bad) begin
          m_ws = mnext(m_ws, sym);
          m_applied = 1'b1;
        end
        m_wb    = (m_phase == SPW - 1);
        m_phase = (m_phase + 1) % SPW;
      end else if (m_mode == 1) begin
        m_mode = 2; m_post = 0;
      end else if (m_post == PC - 1) begin
        m_mode = 0;
      end else begin
        m_post++;
      end
      if (bad) begin m_ws = INIT; m_err = 1'b1; end
    end
    if (LAT == 2) begin
      e_wires = pre_wires; e_drv = pre_drv; e_wb = pre_wb;
    end else begin
      e_wires = mwires(m_mode, m_ws); e_drv = (m_mode != 0); e_wb = m_wb;
    end
  endtask

  task automatic compare_all();
    chk("WireState", WireState, m_ws);
    chk("Wires", {WireA, WireB, WireC}, e_wires);
    chk("HsDrvEn", HsDrvEn, e_drv);
    chk("WordBoundary", WordBoundary, e_wb);
    chk("EncBusy", EncBusy, m_mode != 0);
    chk("IllegalStateErr", IllegalStateErr, m_err);
    if (m_applied) chk_ne("no_repeat_state", WireState, prev_ws);
    prev_ws = WireState;
  endtask

  task automatic step(input logic rn, input logic en, input logic [2:0] sym);
    RstN = rn; HsEncEn = en; SerSym = sym;
    @(posedge clk);
    model_edge(rn, en, sym);
    @(negedge clk);
    compare_all();
  endtask

  typedef struct {
    logic       en;
    logic [2:0] sym;
    int         ws;
  } vec_t;

  vec_t vecs [6];
  int   mask;
  int   held;

  initial begin
    // Burst start (symbol discarded) then the transition sequence from +x.
    vecs[0] = '{1'b1, 3'b111, 0};
    vecs[1] = '{1'b1, 3'b011, 2};
    vecs[2] = '{1'b1, 3'b000, 1};
    vecs[3] = '{1'b1, 3'b100, 0};
    vecs[4] = '{1'b1, 3'b010, 3};
    vecs[5] = '{1'b1, 3'b001, 1};

    m_mode = 0; m_ws = INIT; m_phase = 0; m_post = 0; m_wb = 0; m_err = 0;
    m_applied = 0; e_wires = 0; e_drv = 0; e_wb = 0; prev_ws = 0;
    @(negedge clk);

    // Reset state
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    chk("reset_ws", WireState, 0);
    chk("reset_busy", EncBusy, 0);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].en, vecs[i].sym);
      chk($sformatf("vec%0d_ws", i), WireState, vecs[i].ws);
    end
    step(1'b1, 1'b0, 3'd0);
    if (LAT == 2) chk("first_wires_lat2", {WireA, WireB, WireC}, mwires(1, 1));

    // Word boundary on the 7th and 14th applied symbols
    step(1'b0, 1'b0, 3'd0);
    mask = 0;
    step(1'b1, 1'b1, 3'd0);
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, (k <= 14), 3'($urandom_range(0, 7)));
      if (WordBoundary) mask |= (1 << (k - (LAT - 1)));
    end
    chk("wb_positions", mask, (1 << 7) | (1 << 14));

    // Post-hold length then return to idle
    step(1'b0, 1'b0, 3'd0);
    step(1'b1, 1'b1, 3'd0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 3'($urandom_range(0, 7)));
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 3'd0);
    chk("post_busy_after_7", EncBusy, 1);
    step(1'b1, 1'b0, 3'd0);
    chk("post_busy_after_8", EncBusy, 0);
    step(1'b1, 1'b0, 3'd0);
    chk("post_drv_off", HsDrvEn, 0);
    chk("post_wires_off", {WireA, WireB, WireC}, 0);

    // Resume during post-hold continues from the held state
    step(1'b1, 1'b1, 3'd0);
    step(1'b1, 1'b1, 3'b011);
    step(1'b1, 1'b1, 3'b100);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 3'd0);
    held = m_ws;
    step(1'b1, 1'b1, 3'b011);
    chk("resume_ws", WireState, mnext(held, 3'b011));
    chk("resume_busy", EncBusy, 1);

    // Reset mid-burst
    step(1'b1, 1'b1, 3'b010);
    step(1'b0, 1'b1, 3'b001);
    chk("midrst_ws", WireState, 0);
    chk("midrst_busy", EncBusy, 0);
    chk("midrst_wires", {WireA, WireB, WireC}, 0);

    // Illegal state recovery and sticky error
    step(1'b1, 1'b0, 3'd0);
    force dut.ws_q = 3'd6;
    #1;
    release dut.ws_q;
    m_ws = 6;
    step(1'b1, 1'b0, 3'd0);
    chk("illegal_ws", WireState, 0);
    chk("illegal_err", IllegalStateErr, 1);
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 3'($urandom_range(0, 7)));
    chk("illegal_err_sticky", IllegalStateErr, 1);
    step(1'b0, 1'b0, 3'd0);
    chk("illegal_err_cleared", IllegalStateErr, 0);

    // Randomized run
    for (int k = 0; k < 10000; k++) begin
      step(1'b1, ($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
